// File: rtl/traffic_phase_sequencer_if.sv
// Bundle of the vehicle, timer and light signals around the phase sequencer.
// The master side is the sequencer itself; the slave side is whatever surrounds it
// (detectors, the green timer and the light drivers).
interface traffic_phase_sequencer_if;
  logic       ns_car;
  logic       ew_car;
  logic       tmr_expired;
  logic       tmr_clr;
  logic       tmr_start;
  logic       tmr_extend;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic       wd_fault;

  modport master (
    input  ns_car, ew_car, tmr_expired,
    output tmr_clr, tmr_start, tmr_extend, ns_light, ew_light, phase, wd_fault
  );

  modport slave (
    output ns_car, ew_car, tmr_expired,
    input  tmr_clr, tmr_start, tmr_extend, ns_light, ew_light, phase, wd_fault
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer: NS green/yellow, all-red, EW green/yellow, all-red.
// Green length comes from an external timer that this block clears, starts and
// selects default/extended length for. Yellow and all-red are timed locally.
// Vehicle arrivals per direction decide whether the next green is extended, and a
// watchdog forces the light out of green if the timer never reports expiry.
module traffic_phase_sequencer #(
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int EXTEND_THRESH = 3,
  parameter int MAX_GREEN     = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_phase_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } phaseT;

  localparam int LP_MAXLEN = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
  localparam int LP_CW     = $clog2(LP_MAXLEN + 1);
  localparam int LP_GW     = $clog2(MAX_GREEN + 1);

  localparam logic [LP_CW-1:0] LP_YEL_LOAD = LP_CW'(YELLOW_CYCLES - 1);
  localparam logic [LP_CW-1:0] LP_AR_LOAD  = LP_CW'(ALLRED_CYCLES - 1);
  localparam logic [LP_GW-1:0] LP_WD_LAST  = LP_GW'(MAX_GREEN - 1);
  localparam logic [LP_GW-1:0] LP_ARMED    = LP_GW'(2);
  localparam logic [3:0]       LP_THRESH   = 4'(EXTEND_THRESH);
  localparam logic [3:0]       LP_SAT      = 4'hF;

  localparam logic [2:0] LP_RED = 3'b100;
  localparam logic [2:0] LP_YEL = 3'b010;
  localparam logic [2:0] LP_GRN = 3'b001;

  phaseT             r_state;
  logic [LP_CW-1:0]  r_cnt;
  logic [LP_GW-1:0]  r_greenCnt;
  logic [2:0]        r_nsLight;
  logic [2:0]        r_ewLight;
  logic              r_tmrClr;
  logic              r_tmrStart;
  logic              r_tmrExtend;
  logic              r_wdFault;
  logic [3:0]        r_nsCount;
  logic [3:0]        r_ewCount;

  logic [3:0]        w_nsCarNext;
  logic [3:0]        w_ewCarNext;
  logic              w_nsEnter;
  logic              w_ewEnter;
  logic              w_nsEntryCycle;
  logic              w_ewEntryCycle;
  logic              w_qualExp;
  logic              w_wdHit;
  logic              w_greenExit;

  // Saturating arrival counts as they would stand after this edge if nothing clears them.
  assign w_nsCarNext = (r_nsCount == LP_SAT || !bus.ns_car) ? r_nsCount : r_nsCount + 4'd1;
  assign w_ewCarNext = (r_ewCount == LP_SAT || !bus.ew_car) ? r_ewCount : r_ewCount + 4'd1;

  // Edge that moves all-red into a green, and the first cycle of that green (tmr_clr is high only then).
  assign w_nsEnter      = (r_state == AR2) && (r_cnt == '0);
  assign w_ewEnter      = (r_state == AR1) && (r_cnt == '0);
  assign w_nsEntryCycle = (r_state == NS_G) && r_tmrClr;
  assign w_ewEntryCycle = (r_state == EW_G) && r_tmrClr;

  // Expiry only counts once the timer has had its clear and a full run cycle; the watchdog bounds the rest.
  assign w_qualExp   = bus.tmr_expired && (r_greenCnt >= LP_ARMED);
  assign w_wdHit     = (r_greenCnt == LP_WD_LAST);
  assign w_greenExit = w_qualExp || w_wdHit;

  // Per-direction arrival counters; the green being entered takes its count and a same-cycle arrival is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nsCount <= '0;
      r_ewCount <= '0;
    end else begin
      if (w_nsEnter || w_nsEntryCycle) begin
        r_nsCount <= '0;
      end else begin
        r_nsCount <= w_nsCarNext;
      end
      if (w_ewEnter || w_ewEntryCycle) begin
        r_ewCount <= '0;
      end else begin
        r_ewCount <= w_ewCarNext;
      end
    end
  end

  // Phase FSM with lights and timer controls registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= AR2;
      r_cnt       <= LP_AR_LOAD;
      r_greenCnt  <= '0;
      r_nsLight   <= LP_RED;
      r_ewLight   <= LP_RED;
      r_tmrClr    <= 1'b0;
      r_tmrStart  <= 1'b0;
      r_tmrExtend <= 1'b0;
      r_wdFault   <= 1'b0;
    end else begin
      case (r_state)
        NS_G: begin
          if (w_greenExit) begin
            r_state     <= NS_Y;
            r_cnt       <= LP_YEL_LOAD;
            r_nsLight   <= LP_YEL;
            r_tmrClr    <= 1'b0;
            r_tmrStart  <= 1'b0;
            r_tmrExtend <= 1'b0;
            if (!w_qualExp) begin
              r_wdFault <= 1'b1;
            end
          end else begin
            r_greenCnt <= r_greenCnt + LP_GW'(1);
            r_tmrClr   <= 1'b0;
            r_tmrStart <= 1'b1;
          end
        end
        NS_Y: begin
          if (r_cnt == '0) begin
            r_state   <= AR1;
            r_cnt     <= LP_AR_LOAD;
            r_nsLight <= LP_RED;
          end else begin
            r_cnt <= r_cnt - LP_CW'(1);
          end
        end
        AR1: begin
          if (r_cnt == '0) begin
            r_state     <= EW_G;
            r_ewLight   <= LP_GRN;
            r_greenCnt  <= '0;
            r_tmrClr    <= 1'b1;
            r_tmrStart  <= 1'b0;
            r_tmrExtend <= (w_ewCarNext >= LP_THRESH);
          end else begin
            r_cnt <= r_cnt - LP_CW'(1);
          end
        end
        EW_G: begin
          if (w_greenExit) begin
            r_state     <= EW_Y;
            r_cnt       <= LP_YEL_LOAD;
            r_ewLight   <= LP_YEL;
            r_tmrClr    <= 1'b0;
            r_tmrStart  <= 1'b0;
            r_tmrExtend <= 1'b0;
            if (!w_qualExp) begin
              r_wdFault <= 1'b1;
            end
          end else begin
            r_greenCnt <= r_greenCnt + LP_GW'(1);
            r_tmrClr   <= 1'b0;
            r_tmrStart <= 1'b1;
          end
        end
        EW_Y: begin
          if (r_cnt == '0) begin
            r_state   <= AR2;
            r_cnt     <= LP_AR_LOAD;
            r_ewLight <= LP_RED;
          end else begin
            r_cnt <= r_cnt - LP_CW'(1);
          end
        end
        AR2: begin
          if (r_cnt == '0) begin
            r_state     <= NS_G;
            r_nsLight   <= LP_GRN;
            r_greenCnt  <= '0;
            r_tmrClr    <= 1'b1;
            r_tmrStart  <= 1'b0;
            r_tmrExtend <= (w_nsCarNext >= LP_THRESH);
          end else begin
            r_cnt <= r_cnt - LP_CW'(1);
          end
        end
        default: begin
          r_state     <= AR2;
          r_cnt       <= LP_AR_LOAD;
          r_nsLight   <= LP_RED;
          r_ewLight   <= LP_RED;
          r_tmrClr    <= 1'b0;
          r_tmrStart  <= 1'b0;
          r_tmrExtend <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase      = r_state;
  assign bus.ns_light   = r_nsLight;
  assign bus.ew_light   = r_ewLight;
  assign bus.tmr_clr    = r_tmrClr;
  assign bus.tmr_start  = r_tmrStart;
  assign bus.tmr_extend = r_tmrExtend;
  assign bus.wd_fault   = r_wdFault;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for the traffic phase sequencer. A phase/age reference model tracks which
// light phase the intersection should be in and how long it has been there, the
// queued cars per direction, the extension choice and the watchdog flag. Each test
// task drives its scenario and compares every cycle against that model.
module tb_traffic_phase_sequencer;

  localparam int YEL    = 4;
  localparam int ALLRED = 2;
  localparam int THRESH = 3;
  localparam int MAXG   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nTotal = 0;
  int nBad   = 0;

  traffic_phase_sequencer_if bus();

  traffic_phase_sequencer #(
    .YELLOW_CYCLES(YEL),
    .ALLRED_CYCLES(ALLRED),
    .EXTEND_THRESH(THRESH),
    .MAX_GREEN(MAXG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model: phase 0..5 in ring order, age = cycles spent in the current phase.
  int mPhase = 5;
  int mAge   = 0;
  int mCnt [2] = '{0, 0};
  bit mExt   = 1'b0;
  bit mFault = 1'b0;
  int mDir;
  bit mQual;

  // Stimulus knobs: expMode 0 = expire at green age >= expAge, 1 = held high, 2 = stuck low.
  int expMode = 0;
  int expAge  = 23;
  bit randExp = 1'b0;
  int carRate = 0;

  // Advance the reference model on every rising edge from the inputs held over that edge.
  always @(posedge clk) begin
    if (rst) begin
      mPhase = 5;
      mAge   = 0;
      mCnt[0] = 0;
      mCnt[1] = 0;
      mExt   = 1'b0;
      mFault = 1'b0;
    end else begin
      if (!(mPhase == 0 && mAge == 0) && bus.ns_car === 1'b1 && mCnt[0] < 15) mCnt[0]++;
      if (!(mPhase == 3 && mAge == 0) && bus.ew_car === 1'b1 && mCnt[1] < 15) mCnt[1]++;
      case (mPhase)
        0, 3: begin
          mQual = (mAge >= 2) && (bus.tmr_expired === 1'b1);
          if (mQual || mAge == MAXG - 1) begin
            if (!mQual) mFault = 1'b1;
            mPhase++;
            mAge = 0;
          end else begin
            mAge++;
          end
        end
        1, 4: begin
          if (mAge == YEL - 1) begin
            mPhase++;
            mAge = 0;
          end else begin
            mAge++;
          end
        end
        default: begin
          if (mAge == ALLRED - 1) begin
            mDir   = (mPhase == 5) ? 0 : 1;
            mExt   = (mCnt[mDir] >= THRESH);
            mCnt[mDir] = 0;
            mPhase = (mPhase == 5) ? 0 : 3;
            mAge   = 0;
          end else begin
            mAge++;
          end
        end
      endcase
    end
  end

  // Expected output bundle {phase, ns, ew, clr, start, extend, fault} for the current cycle.
  function automatic logic [14:0] expVec();
    logic [2:0] ns;
    logic [2:0] ew;
    logic       g;
    ns = 3'b100;
    ew = 3'b100;
    case (mPhase)
      0: ns = 3'b001;
      1: ns = 3'b010;
      3: ew = 3'b001;
      4: ew = 3'b010;
      default: ;
    endcase
    g = (mPhase == 0) || (mPhase == 3);
    return {3'(mPhase), ns, ew, g && (mAge == 0), g && (mAge >= 1), g && mExt, mFault};
  endfunction

  function automatic logic [14:0] dutVec();
    return {bus.phase, bus.ns_light, bus.ew_light, bus.tmr_clr, bus.tmr_start,
            bus.tmr_extend, bus.wd_fault};
  endfunction

  // Drive timer expiry and random arrivals for the cycle the model is currently in.
  task automatic applyStimulus();
    bit green;
    green = (mPhase == 0) || (mPhase == 3);
    if (green && mAge == 0 && randExp) expAge = $urandom_range(0, 45);
    case (expMode)
      0:       bus.tmr_expired = green && (mAge >= expAge);
      1:       bus.tmr_expired = 1'b1;
      default: bus.tmr_expired = 1'b0;
    endcase
    bus.ns_car = (carRate != 0) && ($urandom_range(1, carRate) == 1);
    bus.ew_car = (carRate != 0) && ($urandom_range(1, carRate) == 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.ns_car = 1'b0;
    bus.ew_car = 1'b0;
    bus.tmr_expired = 1'b0;
    expMode = 0;
    expAge  = 23;
    randExp = 1'b0;
    carRate = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ns_car = 1'b1;
    bus.ew_car = 1'b1;
    bus.tmr_expired = 1'b1;
    @(negedge clk);
    nTotal++;
    if (bus.phase !== 3'd5) begin
      nBad++;
      $display("[TB] FAIL reset_phase got=%0d want=5", bus.phase);
    end
    nTotal++;
    if ({bus.ns_light, bus.ew_light} !== 6'b100100) begin
      nBad++;
      $display("[TB] FAIL reset_lights got=%b/%b want=100/100", bus.ns_light, bus.ew_light);
    end
    nTotal++;
    if ({bus.tmr_clr, bus.tmr_start, bus.tmr_extend, bus.wd_fault} !== 4'b0000) begin
      nBad++;
      $display("[TB] FAIL reset_ctrl got=%b want=0000",
               {bus.tmr_clr, bus.tmr_start, bus.tmr_extend, bus.wd_fault});
    end
    rst = 1'b0;
    bus.ns_car = 1'b0;
    bus.ew_car = 1'b0;
    bus.tmr_expired = 1'b0;
  endtask

  task automatic test_basic_cycle();
    doReset();
    expAge = 23;
    for (int c = 0; c < 45; c++) begin
      applyStimulus();
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL basic_cycle c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      nTotal++;
      if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
        nBad++;
        $display("[TB] FAIL light_conflict ns=%b ew=%b want one red", bus.ns_light, bus.ew_light);
      end
    end
  endtask

  task automatic test_extend();
    doReset();
    expAge = 10;
    for (int c = 0; c < 60; c++) begin
      applyStimulus();
      bus.ns_car = (mPhase == 4 && mAge == 3) || (mPhase == 5);
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL extend c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      nTotal++;
      if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
        nBad++;
        $display("[TB] FAIL light_conflict ns=%b ew=%b want one red", bus.ns_light, bus.ew_light);
      end
    end
  endtask

  task automatic test_saturation();
    int ewRound;
    ewRound = 0;
    doReset();
    expAge = 30;
    for (int c = 0; c < 200; c++) begin
      applyStimulus();
      if (mPhase == 3 && mAge == 0) ewRound++;
      bus.ns_car = (mPhase == 0 && mAge == 0) ||
                   (mPhase == 3 && mAge < ((ewRound == 1) ? 17 : 2));
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL saturation c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      nTotal++;
      if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
        nBad++;
        $display("[TB] FAIL light_conflict ns=%b ew=%b want one red", bus.ns_light, bus.ew_light);
      end
    end
  endtask

  task automatic test_expiry_guard();
    doReset();
    expMode = 1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus();
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL expiry_guard c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      nTotal++;
      if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
        nBad++;
        $display("[TB] FAIL light_conflict ns=%b ew=%b want one red", bus.ns_light, bus.ew_light);
      end
    end
  endtask

  task automatic test_watchdog();
    doReset();
    expMode = 2;
    for (int c = 0; c < 150; c++) begin
      if (c == 105) begin
        expMode = 0;
        expAge  = 5;
      end
      applyStimulus();
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL watchdog c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      nTotal++;
      if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
        nBad++;
        $display("[TB] FAIL light_conflict ns=%b ew=%b want one red", bus.ns_light, bus.ew_light);
      end
    end
    nTotal++;
    if (bus.wd_fault !== 1'b1) begin
      nBad++;
      $display("[TB] FAIL watchdog_sticky got=%b want=1", bus.wd_fault);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found   = 1'b0;
    expMode = 0;
    expAge  = 8;
    carRate = 0;
    for (int c = 0; c < 120; c++) begin
      applyStimulus();
      bus.ns_car = (mPhase == 3);
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL reset_mid_run c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      if (mPhase == 4 && mAge == 1) begin
        found = 1'b1;
        break;
      end
    end
    nTotal++;
    if (!found) begin
      nBad++;
      $display("[TB] FAIL reset_mid_reach got=no_ew_yellow want=ew_yellow");
    end
    rst = 1'b1;
    bus.ns_car = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ns_car = 1'b0;
    nTotal++;
    if ({bus.phase, bus.ns_light, bus.ew_light} !== 9'b101_100_100) begin
      nBad++;
      $display("[TB] FAIL reset_mid_state got=%0d %b/%b want=5 100/100",
               bus.phase, bus.ns_light, bus.ew_light);
    end
    nTotal++;
    if ({bus.tmr_start, bus.wd_fault} !== 2'b00) begin
      nBad++;
      $display("[TB] FAIL reset_mid_ctrl got=%b want=00", {bus.tmr_start, bus.wd_fault});
    end
    for (int c = 0; c < 30; c++) begin
      applyStimulus();
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL reset_mid_after c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
    end
  endtask

  task automatic test_random();
    doReset();
    randExp = 1'b1;
    carRate = 3;
    for (int c = 0; c < 900; c++) begin
      applyStimulus();
      rst = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      nTotal++;
      if (dutVec() !== expVec()) begin
        nBad++;
        $display("[TB] FAIL random c=%0d got=%h want=%h", c, dutVec(), expVec());
      end
      nTotal++;
      if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
        nBad++;
        $display("[TB] FAIL light_conflict ns=%b ew=%b want one red", bus.ns_light, bus.ew_light);
      end
    end
    rst = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] start");
    test_reset();
    test_basic_cycle();
    test_extend();
    test_saturation();
    test_expiry_guard();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
